alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Initiator side of the ALU operation interface. Accepts decoded RV32I instruction fields plus register/immediate operands from the ID stage over a valid/ready handshake.
- Produces the 4-bit ALU operation code and the X/Y operands, registered. The combinational ALU in EX consumes them directly.
- Contains a 2-entry skid buffer so that EX back-pressure never creates a combinational ready path into ID.

Parameters:
- XLEN, 32, operand width.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- flush  input  1  pipeline flush (branch mispredict/trap)
- in_valid  input  1  ID presents an instruction
- in_ready  output  1  unit can accept; registered, equals !skid_full
- opcode  input  7  instr[6:0]
- funct3  input  3  instr[14:12]
- funct7_5  input  1  instr[30]
- rs1_data  input  XLEN  register operand 1
- rs2_data  input  XLEN  register operand 2
- imm  input  XLEN  sign-extended immediate
- pc  input  XLEN  instruction address
- out_valid  output  1  issued op valid
- out_ready  input  1  EX accepts
- alu_op  output  4  ALU operation code
- alu_x  output  XLEN  ALU X operand
- alu_y  output  XLEN  ALU Y operand
- branch_inv  output  1  EX must invert ALU bit 0 for the branch condition
- illegal  output  1  unsupported encoding

Behaviour:
- Reset (sync, rst=1):
  - out_valid=0, in_ready=1, skid empty.
  - alu_op=SUM (0010); alu_x, alu_y, branch_inv, illegal all 0.
- Handshakes:
  - Input transfer occurs on in_valid&in_ready.
  - Output transfer occurs on out_valid&out_ready.
  - Payload must hold stable while out_valid&!out_ready.
- Latency: 1 cycle from input transfer to out_valid when the output register is empty or draining.
- Buffer states:
  - EMPTY: out_valid=0.
    - Accept → FULL1.
  - FULL1: output register holds an op.
    - Accept with out_ready → FULL1 (new op).
    - Accept without out_ready → FULL2 (new op parked in skid).
    - Drain without accept → EMPTY.
  - FULL2: in_ready=0.
    - out_ready → skid moves to output, FULL1.
- Simultaneous accept and drain in FULL1 is lossless.
- Decode is combinational before the register. Unlisted funct3 in any group gives illegal=1.
- OP (0110011), x=rs1, y=rs2:
  - 000 → SUM, or SUB if funct7_5=1
  - 001 → SHIFT_LEFT
  - 010 → SLT
  - 011 → SLT_U
  - 100 → XOR
  - 101 → SHIFT_RIGHT, or SHIFT_RIGHT_A if funct7_5=1
  - 110 → OR
  - 111 → AND
- OP-IMM (0010011), x=rs1, y=imm:
  - Same map, except 000 is always SUM.
  - For shifts, y={27'b0,imm[4:0]}.
  - A shift with imm[11:5] not in {0000000, 0100000} gives illegal=1.
- LUI: x=0, y=imm, SUM.
- AUIPC: x=pc, y=imm, SUM.
- JAL and JALR: x=pc, y=4, SUM (link value).
- LOAD and STORE: x=rs1, y=imm, SUM.
- BRANCH, x=rs1, y=rs2:
  - BEQ → EQUAL, inv=0
  - BNE → EQUAL, inv=1
  - BLT → SLT, inv=0
  - BGE → GREATER_EQUAL, inv=0
  - BLTU → SLT_U, inv=0
  - BGEU → GREATER_EQUAL_U, inv=0
  - funct3 010/011 → illegal
- Any other opcode: illegal=1, alu_op=SUM, x=y=0.
- Illegal ops still issue with out_valid=1; trap handling is downstream.
- Flush:
  - Next edge: out_valid=0, skid emptied, in_ready=1.
  - Flush overrides a same-cycle input transfer; that instruction is dropped.
- Reset mid-operation behaves as flush and also returns payload registers to their reset values.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Enabled:
  - Adds 32-bit outputs perf_issued and perf_stall, both reset to 0.
  - perf_issued increments on each output transfer.
  - perf_stall increments each cycle with out_valid&!out_ready.
  - Both wrap at 2^32 and are not cleared by flush.
- Disabled: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - ALU op codes: AND=0000, OR=0001, SUM=0010, EQUAL=0011, SHIFT_LEFT=0100, SHIFT_RIGHT=0101, SHIFT_RIGHT_A=0111, XOR=1000, NOR=1001, SUB=1010, GREATER_EQUAL=1100, GREATER_EQUAL_U=1101, SLT=1110, SLT_U=1111.
  - RV32I opcode constants.
  - Packed issue-payload struct: op, x, y, inv, illegal.
- One sub-module, alu_issue_skid: generic 2-entry payload skid buffer with flush.

Test Plan:
- Reset, then ADD rs1=5, rs2=7, in_valid pulse → next cycle out_valid=1, alu_op=0010, x=5, y=7, illegal=0.
- SRAI, imm=0x405 → alu_op=0111, y=5. SLLI with imm[11:5]=0000001 → illegal=1.
- BNE rs1=3, rs2=3 → alu_op=0011, branch_inv=1. BGEU → 1101, inv=0.
- out_ready=0 for 4 cycles while feeding 3 ops:
  - in_ready drops after 2 accepted; payload stays stable.
  - Release → ops drain in order, no loss or duplication.
- Flush while FULL2 and in_valid=1 → next cycle out_valid=0, in_ready=1; the offered op never appears.
- With ALU_ISSUE_PERF_EN: 10 ops with 3 stall cycles → perf_issued=10, perf_stall=3. Flush does not clear them; rst does.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: ALU op codes, RV32I major opcodes
// and the packed payload carried from the issue register into EX.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_AND             = 4'b0000,
    ALU_OR              = 4'b0001,
    ALU_SUM             = 4'b0010,
    ALU_EQUAL           = 4'b0011,
    ALU_SHIFT_LEFT      = 4'b0100,
    ALU_SHIFT_RIGHT     = 4'b0101,
    ALU_SHIFT_RIGHT_A   = 4'b0111,
    ALU_XOR             = 4'b1000,
    ALU_NOR             = 4'b1001,
    ALU_SUB             = 4'b1010,
    ALU_GREATER_EQUAL   = 4'b1100,
    ALU_GREATER_EQUAL_U = 4'b1101,
    ALU_SLT             = 4'b1110,
    ALU_SLT_U           = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    alu_op_e               op;
    logic [ALU_XLEN-1:0]   x;
    logic [ALU_XLEN-1:0]   y;
    logic                  inv;
    logic                  illegal;
  } alu_issue_t;

  localparam alu_issue_t ISSUE_RESET = '{op: ALU_SUM, x: '0, y: '0, inv: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/alu_issue_skid.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one parking
// slot, so in_ready is a pure register and never depends on out_ready.
module alu_issue_skid #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data
);

  logic          out_valid_reg;
  logic          skid_valid_reg;
  logic [W-1:0]  out_data_reg;
  logic [W-1:0]  skid_data_reg;
  logic          accept;
  logic          out_stall;

  assign in_ready  = !skid_valid_reg;
  assign accept    = in_valid && !skid_valid_reg;
  assign out_stall = out_valid_reg && !out_ready;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      out_data_reg   <= RESET_VAL;
      skid_data_reg  <= RESET_VAL;
    end else if (flush) begin
      // Payload is left in place; only the valid bits matter downstream.
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (skid_valid_reg) begin
      if (out_ready) begin
        out_data_reg   <= skid_data_reg;
        skid_valid_reg <= 1'b0;
      end
    end else if (out_stall) begin
      if (accept) begin
        skid_data_reg  <= in_data;
        skid_valid_reg <= 1'b1;
      end
    end else begin
      // Output register is empty or draining this cycle.
      out_valid_reg <= accept;
      if (accept) begin
        out_data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// RV32I ALU issue stage: decodes ID fields into ALU op/operands and registers
// them through a skid buffer. Define ALU_ISSUE_PERF_EN for issue/stall counters.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic [XLEN-1:0]  alu_x,
  output logic [XLEN-1:0]  alu_y,
  output logic             branch_inv,
  output logic             illegal
`ifdef ALU_ISSUE_PERF_EN
  , output logic [31:0]    perf_issued
  , output logic [31:0]    perf_stall
`endif
);

  alu_issue_t dec;
  alu_issue_t issued;
  logic       shamt_ok;

  assign shamt_ok = (imm[11:5] == 7'b0000000) || (imm[11:5] == 7'b0100000);

  always_comb begin
    dec         = ISSUE_RESET;
    dec.illegal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec.x = rs1_data;
        dec.y = (opcode == OPC_OP) ? rs2_data : imm;
        case (funct3)
          3'b000: begin
            if (opcode == OPC_OP && funct7_5) dec.op = ALU_SUB;
            else                              dec.op = ALU_SUM;
          end
          3'b001: dec.op = ALU_SHIFT_LEFT;
          3'b010: dec.op = ALU_SLT;
          3'b011: dec.op = ALU_SLT_U;
          3'b100: dec.op = ALU_XOR;
          3'b101: begin
            if (funct7_5) dec.op = ALU_SHIFT_RIGHT_A;
            else          dec.op = ALU_SHIFT_RIGHT;
          end
          3'b110: dec.op = ALU_OR;
          3'b111: dec.op = ALU_AND;
        endcase
        // Immediate shifts only use the low five bits as the shift amount.
        if (opcode == OPC_OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101)) begin
          dec.y       = {{(ALU_XLEN-5){1'b0}}, imm[4:0]};
          dec.illegal = !shamt_ok;
        end
      end
      OPC_LUI: begin
        dec.y = imm;
      end
      OPC_AUIPC: begin
        dec.x = pc;
        dec.y = imm;
      end
      OPC_JAL, OPC_JALR: begin
        dec.x = pc;
        dec.y = ALU_XLEN'(4);
      end
      OPC_LOAD, OPC_STORE: begin
        dec.x = rs1_data;
        dec.y = imm;
      end
      OPC_BRANCH: begin
        dec.x = rs1_data;
        dec.y = rs2_data;
        case (funct3)
          3'b000: dec.op = ALU_EQUAL;
          3'b001: begin
            dec.op  = ALU_EQUAL;
            dec.inv = 1'b1;
          end
          3'b100: dec.op = ALU_SLT;
          3'b101: dec.op = ALU_GREATER_EQUAL;
          3'b110: dec.op = ALU_SLT_U;
          3'b111: dec.op = ALU_GREATER_EQUAL_U;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  alu_issue_skid #(
    .W         ($bits(alu_issue_t)),
    .RESET_VAL (ISSUE_RESET)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (issued)
  );

  assign alu_op     = issued.op;
  assign alu_x      = issued.x;
  assign alu_y      = issued.y;
  assign branch_inv = issued.inv;
  assign illegal    = issued.illegal;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued_reg;
  logic [31:0] perf_stall_reg;

  // Counters survive flush on purpose; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_reg <= '0;
      perf_stall_reg  <= '0;
    end else begin
      if (out_valid && out_ready)  perf_issued_reg <= perf_issued_reg + 32'd1;
      if (out_valid && !out_ready) perf_stall_reg  <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_issued = perf_issued_reg;
  assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit: decode table, back-pressure,
// flush, mid-operation reset and (when ALU_ISSUE_PERF_EN is set) perf counters.
module tb_alu_issue_unit;

  localparam int XLEN = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  pc;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_op;
  logic [XLEN-1:0]  alu_x;
  logic [XLEN-1:0]  alu_y;
  logic             branch_inv;
  logic             illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]      perf_issued;
  logic [31:0]      perf_stall;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .imm        (imm),
    .pc         (pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_op     (alu_op),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .branch_inv (branch_inv),
    .illegal    (illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_issued (perf_issued)
    , .perf_stall  (perf_stall)
`endif
  );

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f75;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] im;
    logic [31:0] p;
    logic [3:0]  e_op;
    logic [31:0] e_x;
    logic [31:0] e_y;
    logic        e_inv;
    logic        e_ill;
  } vec_t;

  // Outputs are sampled 1 ns after the rising edge, inputs changed there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] o, input logic [2:0] f, input logic f7,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input logic [31:0] p);
    opcode = o; funct3 = f; funct7_5 = f7;
    rs1_data = r1; rs2_data = r2; imm = im; pc = p;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(7'b0110011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (alu_op !== 4'b0010) begin fails++; $display("FAIL reset_alu_op: got %b want 0010", alu_op); end
    checks++; if (alu_x !== 32'd0 || alu_y !== 32'd0) begin fails++; $display("FAIL reset_xy: got %h/%h want 0/0", alu_x, alu_y); end
    checks++; if (branch_inv !== 1'b0 || illegal !== 1'b0) begin fails++; $display("FAIL reset_flags: got inv=%b ill=%b want 0/0", branch_inv, illegal); end
  endtask

  task automatic test_decode();
    vec_t v [16];
    v[0]  = {7'b0110011, 3'b000, 1'b0, 32'd5,          32'd7, 32'd0,          32'd0,     4'b0010, 32'd5,          32'd7,          1'b0, 1'b0};
    v[1]  = {7'b0110011, 3'b000, 1'b1, 32'd10,         32'd3, 32'd0,          32'd0,     4'b1010, 32'd10,         32'd3,          1'b0, 1'b0};
    v[2]  = {7'b0110011, 3'b101, 1'b1, 32'h000000F0,   32'd4, 32'd0,          32'd0,     4'b0111, 32'h000000F0,   32'd4,          1'b0, 1'b0};
    v[3]  = {7'b0010011, 3'b101, 1'b1, 32'h80000000,   32'd9, 32'h00000405,   32'd0,     4'b0111, 32'h80000000,   32'd5,          1'b0, 1'b0};
    v[4]  = {7'b0010011, 3'b001, 1'b0, 32'd1,          32'd0, 32'h00000025,   32'd0,     4'b0100, 32'd1,          32'd5,          1'b0, 1'b1};
    v[5]  = {7'b0010011, 3'b000, 1'b1, 32'd2,          32'd6, 32'h00000400,   32'd0,     4'b0010, 32'd2,          32'h00000400,   1'b0, 1'b0};
    v[6]  = {7'b1100011, 3'b001, 1'b0, 32'd3,          32'd3, 32'd0,          32'd0,     4'b0011, 32'd3,          32'd3,          1'b1, 1'b0};
    v[7]  = {7'b1100011, 3'b111, 1'b0, 32'd4,          32'd9, 32'd0,          32'd0,     4'b1101, 32'd4,          32'd9,          1'b0, 1'b0};
    v[8]  = {7'b1100011, 3'b010, 1'b0, 32'd4,          32'd9, 32'd0,          32'd0,     4'b0010, 32'd4,          32'd9,          1'b0, 1'b1};
    v[9]  = {7'b0110111, 3'b000, 1'b0, 32'd77,         32'd1, 32'h12345000,   32'd0,     4'b0010, 32'd0,          32'h12345000,   1'b0, 1'b0};
    v[10] = {7'b0010111, 3'b000, 1'b0, 32'd77,         32'd1, 32'h00002000,   32'h100,   4'b0010, 32'h100,        32'h00002000,   1'b0, 1'b0};
    v[11] = {7'b1100111, 3'b000, 1'b0, 32'd8,          32'd1, 32'd12,         32'h40,    4'b0010, 32'h40,         32'd4,          1'b0, 1'b0};
    v[12] = {7'b0100011, 3'b010, 1'b0, 32'h1000,       32'd1, 32'hFFFFFFFC,   32'd0,     4'b0010, 32'h1000,       32'hFFFFFFFC,   1'b0, 1'b0};
    v[13] = {7'b1111111, 3'b000, 1'b0, 32'd1,          32'd2, 32'd3,          32'd4,     4'b0010, 32'd0,          32'd0,          1'b0, 1'b1};
    v[14] = {7'b0010011, 3'b011, 1'b0, 32'd1,          32'd8, 32'd5,          32'd0,     4'b1111, 32'd1,          32'd5,          1'b0, 1'b0};
    v[15] = {7'b0110011, 3'b111, 1'b0, 32'hFF00FF00,   32'h0F0F0F0F, 32'd0,   32'd0,     4'b0000, 32'hFF00FF00,   32'h0F0F0F0F,   1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_op(v[i].opc, v[i].f3, v[i].f75, v[i].rs1, v[i].rs2, v[i].im, v[i].p);
      in_valid = 1'b1;
      tick();
      $display("decode[%0d] opc=%b f3=%b -> valid=%b op=%b x=%h y=%h inv=%b ill=%b",
               i, v[i].opc, v[i].f3, out_valid, alu_op, alu_x, alu_y, branch_inv, illegal);
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL decode%0d_valid: got %b want 1", i, out_valid); end
      checks++; if (alu_op !== v[i].e_op) begin fails++; $display("FAIL decode%0d_op: got %b want %b", i, alu_op, v[i].e_op); end
      checks++; if (alu_x !== v[i].e_x || alu_y !== v[i].e_y) begin fails++; $display("FAIL decode%0d_xy: got %h/%h want %h/%h", i, alu_x, alu_y, v[i].e_x, v[i].e_y); end
      checks++; if (branch_inv !== v[i].e_inv || illegal !== v[i].e_ill) begin fails++; $display("FAIL decode%0d_flags: got inv=%b ill=%b want %b/%b", i, branch_inv, illegal, v[i].e_inv, v[i].e_ill); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL decode_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_x [4];
    logic        exp_rdy [4];
    out_ready = 1'b0;
    set_op(7'b0110011, 3'b000, 1'b0, 32'd100, 32'd0, 32'd0, 32'd0);
    in_valid = 1'b1;
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0};
    // Four stalled edges: A accepted, B parked, C refused twice.
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("stall[%0d] in_ready=%b out_valid=%b x=%h", i, in_ready, out_valid, alu_x);
      checks++; if (in_ready !== exp_rdy[i]) begin fails++; $display("FAIL stall%0d_in_ready: got %b want %b", i, in_ready, exp_rdy[i]); end
      checks++; if (out_valid !== 1'b1 || alu_x !== 32'd100) begin fails++; $display("FAIL stall%0d_hold: got v=%b x=%h want 1/64", i, out_valid, alu_x); end
      if (i < 2) rs1_data = 32'd101 + 32'(i);
    end
    out_ready = 1'b1;
    exp_x = '{32'd101, 32'd102, 32'd0, 32'd0};
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("drain[%0d] out_valid=%b x=%h in_ready=%b", i, out_valid, alu_x, in_ready);
      if (i < 2) begin
        checks++; if (out_valid !== 1'b1 || alu_x !== exp_x[i]) begin fails++; $display("FAIL drain%0d: got v=%b x=%h want 1/%h", i, out_valid, alu_x, exp_x[i]); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL drain%0d_in_ready: got %b want 1", i, in_ready); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got out_valid=%b want 0", out_valid); end
      end
      if (i == 1) in_valid = 1'b0;
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_op(7'b0110011, 3'b000, 1'b0, 32'd200, 32'd0, 32'd0, 32'd0);
    in_valid = 1'b1;
    tick();
    rs1_data = 32'd201;
    tick();
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_setup_full: got in_ready=%b want 0", in_ready); end
    rs1_data = 32'd202;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    $display("flush full2 -> out_valid=%b in_ready=%b", out_valid, in_ready);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_full2: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_ghost: got out_valid=%b x=%h want 0", out_valid, alu_x); end
    // Input transfer offered in the same cycle as flush is dropped.
    rs1_data = 32'd203; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drops_input: got out_valid=%b x=%h want 0", out_valid, alu_x); end
    rs1_data = 32'd204; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("after flush issue -> out_valid=%b x=%h", out_valid, alu_x);
    checks++; if (out_valid !== 1'b1 || alu_x !== 32'd204) begin fails++; $display("FAIL flush_recover: got v=%b x=%h want 1/cc", out_valid, alu_x); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_op(7'b1100011, 3'b001, 1'b0, 32'd55, 32'd66, 32'd0, 32'd0);
    in_valid = 1'b1;
    tick(); tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    $display("mid reset -> out_valid=%b in_ready=%b op=%b x=%h", out_valid, in_ready, alu_op, alu_x);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL midrst_handshake: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    checks++; if (alu_op !== 4'b0010 || alu_x !== 32'd0 || alu_y !== 32'd0 || branch_inv !== 1'b0) begin fails++; $display("FAIL midrst_payload: got op=%b x=%h y=%h inv=%b want 0010/0/0/0", alu_op, alu_x, alu_y, branch_inv); end
  endtask

`ifdef ALU_ISSUE_PERF_EN
  task automatic test_perf();
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    set_op(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (i == 4) begin
        out_ready = 1'b0;
        tick(); tick(); tick();
        out_ready = 1'b1;
      end
      tick();
    end
    $display("perf issued=%0d stall=%0d", perf_issued, perf_stall);
    checks++; if (perf_issued !== 32'd10) begin fails++; $display("FAIL perf_issued: got %0d want 10", perf_issued); end
    checks++; if (perf_stall !== 32'd3) begin fails++; $display("FAIL perf_stall: got %0d want 3", perf_stall); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (perf_issued !== 32'd10 || perf_stall !== 32'd3) begin fails++; $display("FAIL perf_flush_keep: got %0d/%0d want 10/3", perf_issued, perf_stall); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (perf_issued !== 32'd0 || perf_stall !== 32'd0) begin fails++; $display("FAIL perf_rst_clear: got %0d/%0d want 0/0", perf_issued, perf_stall); end
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef ALU_ISSUE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
